// File: rtl/ulaplus_ports.sv
// ULAplus register/data port controller with a 2-deep palette write FIFO that yields to atm_palwr.
// Optional palette readback through a shadow RAM is enabled by defining ULAPLUS_READBACK_EN.
module ulaplus_ports (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  input  logic        iowr_s,
  input  logic        iord,
  input  logic        atm_palwr,
  output logic [7:0]  dout,
  output logic        dout_ena,
  output logic        up_ena,
  output logic        up_palwr,
  output logic [5:0]  up_paladdr,
  output logic [7:0]  up_paldata
);

  localparam logic [15:0] REG_PORT = 16'hBF3B;
  localparam logic [15:0] DAT_PORT = 16'hFF3B;

  logic        sel_reg, sel_dat;
  logic [7:0]  regsel;
  logic [13:0] fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_nxt;
  logic        push, pop, pop_mem, store;
  logic [13:0] new_entry, head;
  logic        rd_hit_p0;
  logic [7:0]  rd_data_p0;

  assign sel_reg = (a == REG_PORT);
  assign sel_dat = (a == DAT_PORT);

  // An empty FIFO is bypassed so a write can issue on the very next cycle.
  always_comb begin
    push      = iowr_s && sel_dat && (regsel[7:6] == 2'b00);
    new_entry = {regsel[5:0], din};
    pop       = ((count != 2'd0) || push) && !atm_palwr;
    pop_mem   = pop && (count != 2'd0);
    head      = (count == 2'd0) ? new_entry : fifo_mem[rd_ptr];
    wr_ptr    = rd_ptr ^ count[0];
    store     = push && !((count == 2'd0) && pop) && ((count != 2'd2) || pop);
    count_nxt = count + {1'b0, store} - {1'b0, pop_mem};
  end

  always_ff @(posedge clk) begin
    if (store) fifo_mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regsel     <= 8'h00;
      up_ena     <= 1'b0;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      up_palwr   <= 1'b0;
      up_paladdr <= 6'd0;
      up_paldata <= 8'h00;
    end else begin
      if (iowr_s && sel_reg) regsel <= din;
      if (iowr_s && sel_dat && (regsel[7:6] == 2'b01)) up_ena <= din[0];
      count    <= count_nxt;
      if (pop_mem) rd_ptr <= ~rd_ptr;
      up_palwr <= pop;
      if (pop) begin
        up_paladdr <= head[13:8];
        up_paldata <= head[7:0];
      end
    end
  end

`ifdef ULAPLUS_READBACK_EN
  logic [7:0] shadow [64];

  always_ff @(posedge clk) begin
    if (pop) shadow[head[13:8]] <= head[7:0];
  end
`endif

  // Read stage p0: decode and select; registered onto dout/dout_ena.
  always_comb begin
    rd_hit_p0  = iord && sel_dat;
    rd_data_p0 = 8'hFF;
    case (regsel[7:6])
`ifdef ULAPLUS_READBACK_EN
      2'b00:   rd_data_p0 = shadow[regsel[5:0]];
`else
      2'b00:   rd_data_p0 = 8'hFF;
`endif
      2'b01:   rd_data_p0 = {7'b0, up_ena};
      default: rd_data_p0 = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= 8'hFF;
      dout_ena <= 1'b0;
    end else begin
      dout     <= rd_hit_p0 ? rd_data_p0 : 8'hFF;
      dout_ena <= rd_hit_p0;
    end
  end

endmodule

// File: tb/tb_ulaplus_ports.sv
// Scoreboard bench for ulaplus_ports: expected palette writes are queued at stimulus time
// and popped by a monitor on every up_palwr strobe; register/read results checked directly.
module tb_ulaplus_ports;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        iowr_s = 1'b0;
  logic        iord = 1'b0;
  logic        atm_palwr = 1'b0;
  logic [7:0]  dout;
  logic        dout_ena;
  logic        up_ena;
  logic        up_palwr;
  logic [5:0]  up_paladdr;
  logic [7:0]  up_paldata;

  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q [$];
  logic        atm_prev = 1'b0;

  ulaplus_ports dut (
    .clk(clk), .rst_n(rst_n), .a(a), .din(din), .iowr_s(iowr_s), .iord(iord),
    .atm_palwr(atm_palwr), .dout(dout), .dout_ena(dout_ena), .up_ena(up_ena),
    .up_palwr(up_palwr), .up_paladdr(up_paladdr), .up_paldata(up_paldata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) atm_prev <= atm_palwr;

  // Monitor: every strobe must match the oldest expected write and must not follow a busy ATM cycle.
  always @(negedge clk) begin
    if (rst_n && up_palwr) begin
      checks++;
      if (atm_prev) begin
        errors++;
        $display("FAIL strobe_during_atm: up_palwr=1 after atm_palwr=1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_palwr: got addr=%0h data=%0h expected no strobe",
                 up_paladdr, up_paldata);
      end else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        if ({up_paladdr, up_paldata} !== e) begin
          errors++;
          $display("FAIL palwr_entry: got %0h/%0h expected %0h/%0h",
                   up_paladdr, up_paldata, e[13:8], e[7:0]);
        end
      end
    end
  end

  // Called at #1 after a posedge; occupies exactly one cycle.
  task automatic io_wr(input logic [15:0] addr, input logic [7:0] data);
    a = addr; din = data; iowr_s = 1'b1;
    @(posedge clk); #1;
    iowr_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] exp);
    a = 16'hFF3B; iord = 1'b1;
    idle(2);
    @(negedge clk);
    chk({name, "_dout"}, dout, exp);
    chk({name, "_ena"}, dout_ena, 1'b1);
    @(posedge clk); #1;
    iord = 1'b0; a = 16'h0000;
  endtask

  initial begin
    idle(2);
    @(negedge clk);
    chk("rst_up_ena", up_ena, 0);
    chk("rst_palwr", up_palwr, 0);
    chk("rst_paladdr", up_paladdr, 0);
    chk("rst_paldata", up_paldata, 0);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_dout_ena", dout_ena, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Palette write with one-cycle latency
    io_wr(16'hBF3B, 8'h00);
    exp_q.push_back({6'd0, 8'h5A});
    io_wr(16'hFF3B, 8'h5A);
    @(negedge clk);
    chk("lat_palwr", up_palwr, 1);
    chk("lat_addr", up_paladdr, 0);
    chk("lat_data", up_paldata, 8'h5A);
    chk("lat_up_ena", up_ena, 0);
    @(negedge clk);
    chk("lat_pulse_end", up_palwr, 0);
    chk("hold_data", up_paldata, 8'h5A);
    @(posedge clk); #1;

    // Mode write and mode readback
    io_wr(16'hBF3B, 8'h40);
    io_wr(16'hFF3B, 8'h01);
    @(negedge clk);
    chk("mode_up_ena", up_ena, 1);
    @(posedge clk); #1;
    rd_chk("mode_read", 8'h01);
    idle(1);
    @(negedge clk);
    chk("idle_dout", dout, 8'hFF);
    chk("idle_dout_ena", dout_ena, 0);
    @(posedge clk); #1;

    // Register port is write-only
    a = 16'hBF3B; iord = 1'b1;
    idle(2);
    @(negedge clk);
    chk("regport_no_ena", dout_ena, 0);
    @(posedge clk); #1;
    iord = 1'b0;

    // Writes wait while ATM owns the palette, then issue back to back
    atm_palwr = 1'b1;
    io_wr(16'hBF3B, 8'h03);
    exp_q.push_back({6'd3, 8'h11});
    io_wr(16'hFF3B, 8'h11);
    io_wr(16'hBF3B, 8'h04);
    exp_q.push_back({6'd4, 8'h22});
    io_wr(16'hFF3B, 8'h22);
    idle(1);
    atm_palwr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("atm_first_palwr", up_palwr, 1);
    chk("atm_first_addr", up_paladdr, 6'd3);
    @(negedge clk);
    chk("atm_second_palwr", up_palwr, 1);
    chk("atm_second_addr", up_paladdr, 6'd4);
    @(negedge clk);
    chk("atm_done", up_palwr, 0);
    @(posedge clk); #1;

    // Third write into a full FIFO is dropped
    atm_palwr = 1'b1;
    io_wr(16'hBF3B, 8'h05);
    exp_q.push_back({6'd5, 8'hA1});
    io_wr(16'hFF3B, 8'hA1);
    exp_q.push_back({6'd5, 8'hA2});
    io_wr(16'hFF3B, 8'hA2);
    io_wr(16'hFF3B, 8'hA3);
    idle(2);
    atm_palwr = 1'b0;
    idle(6);
    chk("drop_last_data", up_paldata, 8'hA2);

    // Shadow readback of the last palette entry
    io_wr(16'hBF3B, 8'h3F);
    exp_q.push_back({6'h3F, 8'hE3});
    io_wr(16'hFF3B, 8'hE3);
    idle(3);
`ifdef ULAPLUS_READBACK_EN
    rd_chk("pal_read", 8'hE3);
`else
    rd_chk("pal_read", 8'hFF);
`endif

    // Mid-operation reset discards pending entries
    atm_palwr = 1'b1;
    io_wr(16'hBF3B, 8'h07);
    io_wr(16'hFF3B, 8'h55);
    io_wr(16'hFF3B, 8'h66);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_up_ena", up_ena, 0);
    chk("arst_palwr", up_palwr, 0);
    chk("arst_paladdr", up_paladdr, 0);
    chk("arst_dout", dout, 8'hFF);
    atm_palwr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(10);
    chk("post_rst_up_ena", up_ena, 0);
    chk("post_rst_dout", dout, 8'hFF);
`ifdef ULAPLUS_READBACK_EN
    rd_chk("post_rst_read", 8'h5A);
`else
    rd_chk("post_rst_read", 8'hFF);
`endif

    // Bounded drain of any expected strobe still outstanding
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
